// File: rtl/req_grant_sequencer.sv
// Sequential front-end for an N-way priority selector: queues request strobes,
// holds the selected grant as bus ownership until done or a hold timeout.

module rgs_pend_cell (
  input  logic clock,
  input  logic reset_n,
  input  logic set,
  input  logic clr,
  output logic q
);
  // set dominates clr so an owner re-requesting on its release edge stays queued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  q <= 1'b0;
    else if (set)  q <= 1'b1;
    else if (clr)  q <= 1'b0;
  end
endmodule

module req_grant_sequencer #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req_pulse,
  input  logic             done,
  output logic [N-1:0]     sel_req,
  output logic             sel_en,
  input  logic [N-1:0]     sel_gnt,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;

  state_t             state, state_nxt;
  logic [N-1:0]       pending, clr_mask, grant_nxt;
  logic [IDX_W-1:0]   idx_nxt, gnt_enc;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               valid_nxt, to_nxt, tmo_hit;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_pend
      rgs_pend_cell u_cell (
        .clock   (clock),
        .reset_n (reset_n),
        .set     (req_pulse[g]),
        .clr     (clr_mask[g]),
        .q       (pending[g])
      );
    end
  endgenerate

  assign sel_req = pending;
  assign tmo_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

  always_comb begin
    gnt_enc = '0;
    for (int i = 0; i < N; i++)
      if (sel_gnt[i]) gnt_enc = IDX_W'(i);
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    valid_nxt = grant_valid;
    cnt_nxt   = cnt;
    to_nxt    = 1'b0;
    clr_mask  = '0;
    sel_en    = 1'b0;
    case (state)
      IDLE: if (|pending) state_nxt = ARB;
      ARB: begin
        sel_en = 1'b1;
        if (|sel_gnt) begin
          grant_nxt = sel_gnt;
          idx_nxt   = gnt_enc;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (done || tmo_hit) begin
          clr_mask  = grant;
          to_nxt    = !done;
          grant_nxt = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
          // decide on the pending vector as it will look after this edge
          state_nxt = (|((pending & ~grant) | req_pulse)) ? ARB : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      timeout     <= to_nxt;
      cnt         <= cnt_nxt;
    end
  end
endmodule

// File: doc/req_grant_sequencer.md
Name: req_grant_sequencer

Overview:
- Sequential front-end for the 4-bit priority selector (req/en/gnt).
- Latches one-cycle request pulses into a sticky pending vector and drives that vector plus enable into the selector.
- Registers the selector's one-hot grant and holds it as a bus-ownership grant until the owner signals done or a hold timeout expires.
- Clears the served request and re-arbitrates.

Parameters:
- N, 4, number of requesters. Width of all request and grant vectors; must match the selector instance.
- TIMEOUT, 16, maximum cycles a grant may be held in BUSY. 0 disables the timeout.
- IDX_W, $clog2(N), width of grant_idx. Derived; not overridden.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_pulse  input  N  one-cycle request strobes, one bit per requester
- done  input  1  current owner finished its transaction; sampled only in BUSY
- sel_req  output  N  pending vector driven to selector req
- sel_en  output  1  selector enable
- sel_gnt  input  N  one-hot grant returned combinationally by the selector
- grant  output  N  registered one-hot ownership grant
- grant_idx  output  IDX_W  binary index of the set grant bit; 0 when grant_valid=0
- grant_valid  output  1  grant holds a live owner
- timeout  output  1  one-cycle pulse when a grant is force-released by timeout

Behaviour:
- Reset: asynchronous on reset_n low, regardless of clock. Cleared values:
  - pending=0, grant=0, grant_idx=0, grant_valid=0, timeout=0, hold counter=0.
  - state=IDLE.
  - Reset asserted mid-BUSY drops the grant immediately and loses all pending requests.
- Pending vector:
  - pending[i] sets at the edge where req_pulse[i]=1.
  - pending[owner] clears at the release edge (done or timeout).
  - If req_pulse[owner] and release occur in the same cycle, set wins and the owner stays queued.
  - A req_pulse on an already-pending bit has no effect; requests do not count.
- sel_req = pending (registered, no combinational path from req_pulse). sel_en = 1 only in state ARB.
- FSM states IDLE, ARB, BUSY:
  - IDLE: if pending!=0, go to ARB next edge; otherwise stay.
  - ARB: sel_en=1. At the next edge, grant<=sel_gnt, grant_idx<=encode(sel_gnt), grant_valid<=1, counter<=0, state<=BUSY. If sel_gnt==0 (not reachable with correct selector), return to IDLE with grant unchanged at 0.
  - BUSY: counter increments each cycle.
    - done=1: release at that edge. grant, grant_idx and grant_valid go to 0; pending[owner] clears (subject to the set-wins rule).
    - Next state after release: ARB if the post-update pending vector is nonzero, else IDLE.
    - TIMEOUT>0, counter==TIMEOUT-1 and done=0: same release, and timeout=1 for exactly the following cycle.
    - done and the timeout condition in the same cycle: treated as done; no timeout pulse.
- done outside BUSY is ignored.
- Latency:
  - req_pulse seen at edge k → pending at k, ARB at k+1, grant_valid at k+2 (i.e., grant visible 2 cycles after the pulse edge).
  - Minimum grant tenure is 1 cycle. Minimum gap between consecutive grants is 1 cycle (ARB).
- Priority comes entirely from the selector (highest index wins). The block adds no fairness.
- grant must be one-hot or zero at all times. The bench asserts this and that grant_valid == |grant.

Test Plan:
1. Reset with all requests idle, then req_pulse=4'b0100 for 1 cycle → 2 cycles later grant=0100, grant_idx=2, grant_valid=1. done pulse → next cycle grant=0, pending=0, state IDLE.
2. Simultaneous req_pulse=4'b1011 → grants in order 1000, 0010, 0001. Each follows done, with one ARB bubble cycle (grant_valid=0) between tenures.
3. TIMEOUT=16, req_pulse=0001, done never asserted → grant_valid high for 16 cycles, then grant=0, timeout=1 for one cycle, pending[0]=0. With TIMEOUT=0, the grant holds indefinitely.
4. Owner 3 holding; req_pulse[3] and done in the same cycle → pending[3] stays 1, FSM goes ARB, and grant=1000 is re-issued.
5. reset_n dropped asynchronously mid-BUSY with pending=1110 → outputs 0 immediately (before the next edge). After release, no grant until a new req_pulse.
6. done and the timeout condition in the same cycle; done in IDLE → no timeout pulse, normal release; IDLE done has no state change.
